// File: rtl/gshare_pattern_table.sv
// gshare_pattern_table: 2-bit saturating counter table indexed by PC ^ history,
// with a registered prediction and a post-reset initialisation sweep.
module gshare_pattern_table #(
    parameter int M     = 4,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pred_valid_i,
    input  logic [IDX_W-1:0] pred_pc_i,
    input  logic [M-1:0]     bhr_i,
    output logic             pred_valid_o,
    output logic             pred_taken_o,
    output logic [IDX_W-1:0] pred_idx_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    output logic             init_busy_o
);
    typedef enum logic {INIT, RUN} state_t;
    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [1:0]       ctr_q [2**IDX_W];
    logic [1:0]       cur;
    logic [1:0]       nxt;
    assign idx = pred_pc_i ^ IDX_W'(bhr_i);
    assign cur = ctr_q[upd_idx_i];
    always_comb nxt = upd_taken_i ? ((cur == 2'b11) ? cur : cur + 2'd1)
                                  : ((cur == 2'b00) ? cur : cur - 2'd1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= INIT;
            ptr          <= '0;
            pred_valid_o <= 1'b0;
            pred_taken_o <= 1'b0;
            pred_idx_o   <= '0;
            init_busy_o  <= 1'b1;
        end else begin
            pred_valid_o <= pred_valid_i;
            if (pred_valid_i) begin
                pred_idx_o   <= idx;
                pred_taken_o <= (state == RUN) && ctr_q[idx][1];
            end
            if (state == INIT) begin
                ptr <= ptr + IDX_W'(1);
                if (&ptr) begin
                    state       <= RUN;
                    init_busy_o <= 1'b0;
                end
            end
        end
    end
    // Counters carry no reset; the sweep is their only initialisation.
    always_ff @(posedge clk) begin
        if (state == INIT)
            ctr_q[ptr] <= 2'b01;
        else if (upd_valid_i)
            ctr_q[upd_idx_i] <= nxt;
    end
endmodule

// File: tb/tb_gshare_pattern_table.sv
// tb_gshare_pattern_table: scoreboard bench for the gshare counter table.
module tb_gshare_pattern_table;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       pred_valid_i = 1'b0;
    logic [5:0] pred_pc_i = '0;
    logic [3:0] bhr_i = '0;
    logic       pred_valid_o;
    logic       pred_taken_o;
    logic [5:0] pred_idx_o;
    logic       upd_valid_i = 1'b0;
    logic [5:0] upd_idx_i = '0;
    logic       upd_taken_i = 1'b0;
    logic       init_busy_o;

    typedef struct packed {
        logic [5:0] idx;
        logic       taken;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] model [64];
    int         checks = 0;
    int         failures = 0;

    gshare_pattern_table #(.M(4), .IDX_W(6)) dut (
        .clk(clk), .reset_n(reset_n),
        .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i), .bhr_i(bhr_i),
        .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_idx_o(pred_idx_o),
        .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i), .upd_taken_i(upd_taken_i),
        .init_busy_o(init_busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Every valid prediction is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (reset_n && pred_valid_o) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: pred_valid_o=1 idx=%0h with no pending request", pred_idx_o);
            end else begin
                e = exp_q.pop_front();
                if (pred_idx_o !== e.idx || pred_taken_o !== e.taken) begin
                    failures++;
                    $display("FAIL sb_pred: got idx=%0h taken=%0b, expected idx=%0h taken=%0b",
                             pred_idx_o, pred_taken_o, e.idx, e.taken);
                end
            end
        end
    end

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
        return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction

    task automatic model_init();
        for (int i = 0; i < 64; i++) model[i] = 2'b01;
    endtask

    // Prediction is captured from the model before the update: read-before-write.
    task automatic drive(input logic pv, input logic [5:0] pc, input logic [3:0] bhr,
                         input logic uv, input logic [5:0] uidx, input logic ut, input logic init);
        logic [5:0] i;
        @(negedge clk);
        pred_valid_i = pv;
        pred_pc_i    = pc;
        bhr_i        = bhr;
        upd_valid_i  = uv;
        upd_idx_i    = uidx;
        upd_taken_i  = ut;
        if (pv) begin
            i = pc ^ {2'b00, bhr};
            exp_q.push_back('{idx: i, taken: init ? 1'b0 : model[i][1]});
        end
        if (uv && !init) model[uidx] = sat(model[uidx], ut);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        int n;
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (pred_valid_o !== 1'b0 || pred_taken_o !== 1'b0 || pred_idx_o !== 6'h00 || init_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_values: valid=%0b taken=%0b idx=%0h busy=%0b, expected 0 0 0 1",
                     pred_valid_o, pred_taken_o, pred_idx_o, init_busy_o);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_init();
        n = 0;
        while (init_busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 64) begin
            failures++;
            $display("FAIL init_busy_len: busy for %0d cycles, expected 64", n);
        end
    endtask

    task automatic test_init_predict();
        for (int p = 0; p < 64; p++) drive(1'b1, 6'(p), 4'h0, 1'b0, '0, 1'b0, 1'b0);
        idle();
        checks++;
        if (pred_taken_o !== 1'b0 || pred_idx_o !== 6'd63) begin
            failures++;
            $display("FAIL init_predict_last: taken=%0b idx=%0h, expected 0 3f", pred_taken_o, pred_idx_o);
        end
        idle();
    endtask

    task automatic test_index();
        drive(1'b1, 6'h2A, 4'hF, 1'b0, '0, 1'b0, 1'b0);
        idle();
        checks++;
        if (pred_valid_o !== 1'b1 || pred_idx_o !== 6'h25) begin
            failures++;
            $display("FAIL index_calc: valid=%0b idx=%0h, expected 1 25", pred_valid_o, pred_idx_o);
        end
        idle();
        checks++;
        if (pred_valid_o !== 1'b0 || pred_idx_o !== 6'h25) begin
            failures++;
            $display("FAIL index_hold: valid=%0b idx=%0h, expected 0 25", pred_valid_o, pred_idx_o);
        end
    endtask

    task automatic test_update();
        drive(1'b0, '0, '0, 1'b1, 6'd5, 1'b1, 1'b0);
        drive(1'b1, 6'd5, 4'h0, 1'b0, '0, 1'b0, 1'b0);
        idle();
        checks++;
        if (pred_taken_o !== 1'b1) begin
            failures++;
            $display("FAIL update_taken: taken=%0b, expected 1", pred_taken_o);
        end
    endtask

    task automatic test_saturation();
        repeat (4) drive(1'b0, '0, '0, 1'b1, 6'd9, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 6'd9, 1'b0, 1'b0);
        drive(1'b1, 6'd9, 4'h0, 1'b0, '0, 1'b0, 1'b0);
        idle();
        checks++;
        if (pred_taken_o !== 1'b1) begin
            failures++;
            $display("FAIL sat_high: taken=%0b, expected 1 (ctr 10)", pred_taken_o);
        end
        repeat (4) drive(1'b0, '0, '0, 1'b1, 6'd9, 1'b0, 1'b0);
        drive(1'b1, 6'd9, 4'h0, 1'b0, '0, 1'b0, 1'b0);
        repeat (2) drive(1'b0, '0, '0, 1'b1, 6'd9, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 6'd9, 1'b1, 1'b0);
        drive(1'b1, 6'd9, 4'h0, 1'b0, '0, 1'b0, 1'b0);
        idle();
        checks++;
        if (pred_taken_o !== 1'b0) begin
            failures++;
            $display("FAIL sat_low: taken=%0b, expected 0 (ctr 01)", pred_taken_o);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 6'd7, 4'h0, 1'b1, 6'd7, 1'b1, 1'b0);
        drive(1'b1, 6'd7, 4'h0, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (pred_taken_o !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_rbw: taken=%0b, expected 0", pred_taken_o);
        end
        idle();
        checks++;
        if (pred_taken_o !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_next: taken=%0b, expected 1", pred_taken_o);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++)
            drive(1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
        idle();
        idle();
    endtask

    task automatic test_reset_mid();
        int n;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_init();
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (init_busy_o !== 1'b1 || pred_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: busy=%0b valid=%0b, expected 1 0", init_busy_o, pred_valid_o);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n      = 1'b1;
        pred_valid_i = 1'b1;
        pred_pc_i    = 6'd3;
        bhr_i        = 4'h0;
        upd_valid_i  = 1'b1;
        upd_idx_i    = 6'd11;
        upd_taken_i  = 1'b1;
        exp_q.push_back('{idx: 6'd3, taken: 1'b0});
        n = 0;
        while (init_busy_o && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                pred_valid_i = 1'b0;
                upd_valid_i  = 1'b0;
                upd_idx_i    = 6'd11;
                repeat (3) begin
                    upd_valid_i = 1'b1;
                    @(negedge clk);
                    n++;
                end
                upd_valid_i = 1'b0;
            end
        end
        checks++;
        if (n != 64) begin
            failures++;
            $display("FAIL reinit_busy_len: busy for %0d cycles, expected 64", n);
        end
        drive(1'b1, 6'd11, 4'h0, 1'b0, '0, 1'b0, 1'b0);
        idle();
        checks++;
        if (pred_taken_o !== 1'b0 || pred_idx_o !== 6'd11) begin
            failures++;
            $display("FAIL ignored_update: taken=%0b idx=%0h, expected 0 0b", pred_taken_o, pred_idx_o);
        end
    endtask

    initial begin
        test_reset();
        test_init_predict();
        test_index();
        test_update();
        test_saturation();
        test_back_to_back();
        test_random();
        test_reset_mid();
        idle();
        idle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d predictions outstanding, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
